// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states, owner encoding, poison address.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  // Reset value of mem_addr and the data returned on a memory timeout.
  localparam logic [31:0] ADDR_INVALID = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one wishbone-style memory port between I-fetch miss (I) and the D-cache MSHR (D).
// Latency: req seen in IDLE -> mem_req next cycle -> x_valid one cycle after mem_valid.
// Backpressure: requesters hold req level until their x_valid; one transaction in flight.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   i_req/i_addr -> i_valid/i_rdata                I-fetch read requester
//   d_req/d_we/d_addr/d_wdata -> d_valid/d_rdata   D-cache read/write requester
//   mem_req/mem_we/mem_addr/mem_wdata, mem_rdata/mem_valid    memory port
//   busy, grant_d, err             status: not idle, current/last owner is D, sticky timeout
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_valid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  output logic        busy,
  output logic        grant_d,
  output logic        err
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam int TIMER_W  = $clog2(TIMEOUT);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  owner_t              r_owner;
  logic [STREAK_W-1:0] r_streak;
  logic [TIMER_W-1:0]  r_timer;
  logic                r_mem_we;
  logic [31:0]         r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic [31:0]         r_rdata;
  logic                r_err;

  logic w_grant;
  logic w_pick_d;
  logic w_resp_ok;
  logic w_resp_to;

  // D wins unless I is waiting and D has already used up its streak allowance.
  function automatic logic f_pick_d(input logic d, input logic i,
                                    input logic [STREAK_W-1:0] streak);
    return d && !(i && (streak == STREAK_MAX));
  endfunction

  assign w_pick_d = f_pick_d(d_req, i_req, r_streak);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_resp_ok   = 1'b0;
    w_resp_to   = 1'b0;
    case (r_state)
      IDLE: begin
        if (d_req || i_req) begin
          w_grant     = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        // A completion in the final timer cycle still counts as a normal response.
        if (mem_valid) begin
          w_resp_ok   = 1'b1;
          w_state_nxt = RESP;
        end else if (r_timer == TIMER_LAST) begin
          w_resp_to   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= OWN_I;
      r_streak    <= '0;
      r_timer     <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= ADDR_INVALID;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_grant) begin
        r_owner     <= w_pick_d ? OWN_D : OWN_I;
        r_mem_we    <= w_pick_d & d_we;
        r_mem_addr  <= w_pick_d ? d_addr : i_addr;
        r_mem_wdata <= w_pick_d ? d_wdata : '0;
        // Streak only grows while I is actually being held off.
        if (w_pick_d && i_req) begin
          if (r_streak != STREAK_MAX) begin
            r_streak <= r_streak + STREAK_W'(1);
          end
        end else begin
          r_streak <= '0;
        end
      end
      if (r_state == ISSUE) begin
        r_timer <= '0;
      end else if (r_state == WAIT) begin
        r_timer <= r_timer + TIMER_W'(1);
      end
      if (w_resp_ok) begin
        r_rdata <= (r_owner == OWN_D && r_mem_we) ? '0 : mem_rdata;
      end
      if (w_resp_to) begin
        r_rdata <= ADDR_INVALID;
        r_err   <= 1'b1;
      end
    end
  end

  assign mem_req   = (r_state == ISSUE);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != IDLE);
  assign grant_d   = (r_owner == OWN_D);
  assign err       = r_err;
  assign i_valid   = (r_state == RESP) && (r_owner == OWN_I);
  assign d_valid   = (r_state == RESP) && (r_owner == OWN_D);
  assign i_rdata   = (r_owner == OWN_I) ? r_rdata : '0;
  assign d_rdata   = (r_owner == OWN_D) ? r_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model plus directed scenarios.
// Latency: n/a.
// Backpressure: requester agents hold req until their valid pulse.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req, d_req, d_we, mem_valid;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_valid, d_valid, mem_req, mem_we, busy, grant_d, err;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .busy(busy), .grant_d(grant_d), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- requester agents ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } d_op_t;

  d_op_t       d_q[$];
  logic [31:0] i_q[$];
  bit          d_done = 0;
  bit          i_done = 0;

  initial begin
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    forever begin
      @(posedge clk);
      #2;
      if (d_done) begin void'(d_q.pop_front()); d_done = 0; end
      if (i_done) begin void'(i_q.pop_front()); i_done = 0; end
      if (d_q.size() > 0) begin
        d_req = 1; d_we = d_q[0].we; d_addr = d_q[0].addr; d_wdata = d_q[0].wdata;
      end else begin
        d_req = 0;
      end
      if (i_q.size() > 0) begin
        i_req = 1; i_addr = i_q[0];
      end else begin
        i_req = 0;
      end
    end
  end

  // ---------------- memory model ----------------
  int          mem_lat = 1;   // 0 = never answers
  int          pend = 0;
  logic [31:0] pend_addr = 0;
  bit          stray_req = 0;

  initial begin
    mem_valid = 0; mem_rdata = 0;
    forever begin
      tick();
      mem_valid = 0;
      mem_rdata = 32'h0BAD_0000 | 32'(cyc);
      if (stray_req) begin
        mem_valid = 1;
        stray_req = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_valid = 1;
          mem_rdata = pend_addr ^ 32'h1234_5678;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) pend = 0;
      else if (mem_req && mem_lat > 0) begin
        pend = mem_lat;
        pend_addr = mem_addr;
      end
    end
  end

  // ---------------- reference model + compare ----------------
  bit          have_txn = 0, m_own_d = 0, m_last_d = 0, m_mwe = 0;
  int          t_start = 0, t_done = -1, m_err_at = -1, m_streak = 0;
  logic [31:0] m_addr = 32'hDEAD_BEEF, m_wdata = 0, t_rdata = 0;
  bit          idle, resp, pick_d;

  bit          log_d[$];
  int          log_cyc[$];
  logic [31:0] log_dat[$];
  int          n_memreq = 0;
  logic        snap_we = 0;
  logic [31:0] snap_addr = 0, snap_wdata = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_i_valid", i_valid, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_grant_d", grant_d, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_addr", mem_addr, 32'hDEAD_BEEF);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        have_txn = 0; m_streak = 0; m_err_at = -1; m_last_d = 0;
        m_addr = 32'hDEAD_BEEF; m_mwe = 0; m_wdata = 0;
      end else begin
        idle = !have_txn || (t_done >= 0 && cyc > t_done);
        resp = have_txn && (t_done == cyc);
        chk("busy", busy, !idle);
        chk("mem_req", mem_req, have_txn && (cyc == t_start + 1));
        chk("d_valid", d_valid, resp && m_own_d);
        chk("i_valid", i_valid, resp && !m_own_d);
        if (resp && m_own_d) chk("d_rdata", d_rdata, t_rdata);
        if (resp && !m_own_d) chk("i_rdata", i_rdata, t_rdata);
        chk("mem_we", mem_we, m_mwe);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("grant_d", grant_d, m_last_d);
        chk("err", err, (m_err_at >= 0) && (cyc >= m_err_at));

        if (mem_req) begin
          n_memreq++; snap_we = mem_we; snap_addr = mem_addr; snap_wdata = mem_wdata;
        end
        if (d_valid) begin
          log_d.push_back(1); log_cyc.push_back(cyc); log_dat.push_back(d_rdata); d_done = 1;
        end
        if (i_valid) begin
          log_d.push_back(0); log_cyc.push_back(cyc); log_dat.push_back(i_rdata); i_done = 1;
        end

        // Advance the transaction model with this cycle's inputs.
        if (idle) begin
          have_txn = 0;
          if (d_req || i_req) begin
            pick_d = d_req && !(i_req && m_streak == 4);
            if (pick_d && i_req) m_streak = (m_streak < 4) ? m_streak + 1 : 4;
            else m_streak = 0;
            have_txn = 1; t_start = cyc; t_done = -1; m_own_d = pick_d; m_last_d = pick_d;
            m_mwe   = pick_d ? d_we : 1'b0;
            m_addr  = pick_d ? d_addr : i_addr;
            m_wdata = pick_d ? d_wdata : 32'h0;
          end
        end else if (t_done < 0 && cyc >= t_start + 2) begin
          if (mem_valid) begin
            t_done = cyc + 1;
            t_rdata = (m_own_d && m_mwe) ? 32'h0 : mem_rdata;
          end else if (cyc - (t_start + 2) == 63) begin
            t_done = cyc + 1;
            t_rdata = 32'hDEAD_BEEF;
            if (m_err_at < 0) m_err_at = cyc + 1;
          end
        end
      end
    end
  end

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((d_q.size() > 0 || i_q.size() > 0 || busy) && n < budget);
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_done: still busy after %0d cycles, required idle", name, budget);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  int t0, base, nreq0;
  bit exp3[7];

  initial begin
    exp3 = '{1, 1, 1, 1, 0, 1, 1};
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    tick();
    chk("init_mem_addr", mem_addr, 32'hDEAD_BEEF);
    chk("init_busy", busy, 0);

    // 1: lone D read, latency 3
    base = log_d.size(); nreq0 = n_memreq; mem_lat = 3; t0 = cyc;
    d_q.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0});
    wait_idle(100, "t1");
    chk("t1_nresp", log_d.size() - base, 1);
    chk("t1_memreq_cnt", n_memreq - nreq0, 1);
    chk("t1_mem_we", snap_we, 0);
    chk("t1_mem_addr", snap_addr, 32'h40);
    if (log_d.size() > base) begin
      chk("t1_owner", log_d[base], 1);
      chk("t1_latency", log_cyc[base] - t0, 5);
      chk("t1_rdata", log_dat[base], 32'h1234_5638);
    end

    // 2: both raised together, D first, then I after one IDLE gap
    base = log_d.size(); mem_lat = 2; t0 = cyc;
    d_q.push_back('{we: 1'b0, addr: 32'h44, wdata: 32'h0});
    i_q.push_back(32'h48);
    wait_idle(100, "t2");
    chk("t2_nresp", log_d.size() - base, 2);
    if (log_d.size() >= base + 2) begin
      chk("t2_first_owner", log_d[base], 1);
      chk("t2_second_owner", log_d[base+1], 0);
      chk("t2_d_latency", log_cyc[base] - t0, 4);
      chk("t2_i_latency", log_cyc[base+1] - t0, 9);
      chk("t2_d_rdata", log_dat[base], 32'h1234_563C);
      chk("t2_i_rdata", log_dat[base+1], 32'h1234_5630);
    end

    // 3: D held continuously with I pending -> 4 D, then I, then D
    base = log_d.size(); mem_lat = 1;
    for (int k = 0; k < 6; k++) d_q.push_back('{we: 1'b0, addr: 32'h1000 + 32'(4*k), wdata: 32'h0});
    i_q.push_back(32'h2000);
    wait_idle(200, "t3");
    chk("t3_nresp", log_d.size() - base, 7);
    if (log_d.size() >= base + 7) begin
      for (int k = 0; k < 7; k++) chk($sformatf("t3_owner%0d", k), log_d[base+k], exp3[k]);
    end

    // 4: D write
    base = log_d.size(); mem_lat = 2;
    d_q.push_back('{we: 1'b1, addr: 32'h80, wdata: 32'hCAFE_F00D});
    wait_idle(100, "t4");
    chk("t4_mem_we", snap_we, 1);
    chk("t4_mem_addr", snap_addr, 32'h80);
    chk("t4_mem_wdata", snap_wdata, 32'hCAFE_F00D);
    chk("t4_nresp", log_d.size() - base, 1);
    if (log_d.size() > base) begin
      chk("t4_owner", log_d[base], 1);
      chk("t4_rdata", log_dat[base], 32'h0);
    end

    // 5: memory never answers -> timeout, then a stray mem_valid in IDLE
    base = log_d.size(); mem_lat = 0; t0 = cyc;
    i_q.push_back(32'h100);
    wait_idle(200, "t5");
    chk("t5_err", err, 1);
    chk("t5_nresp", log_d.size() - base, 1);
    if (log_d.size() > base) begin
      chk("t5_owner", log_d[base], 0);
      chk("t5_latency", log_cyc[base] - t0, 66);
      chk("t5_rdata", log_dat[base], 32'hDEAD_BEEF);
    end
    base = log_d.size();
    stray_req = 1;
    repeat (5) tick();
    chk("t5_stray_nresp", log_d.size() - base, 0);
    chk("t5_stray_busy", busy, 0);
    chk("t5_err_sticky", err, 1);

    // 6: reset during WAIT, held requests re-granted afterwards
    base = log_d.size(); mem_lat = 8; t0 = cyc;
    d_q.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0});
    i_q.push_back(32'h300);
    repeat (4) tick();
    chk("t6_busy_before_rst", busy, 1);
    rst_n = 0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_mem_addr", mem_addr, 32'hDEAD_BEEF);
    repeat (2) tick();
    stray_req = 1;
    tick();
    rst_n = 1;
    wait_idle(200, "t6");
    chk("t6_nresp", log_d.size() - base, 2);
    if (log_d.size() >= base + 2) begin
      chk("t6_first_owner", log_d[base], 1);
      chk("t6_second_owner", log_d[base+1], 0);
      chk("t6_d_rdata", log_dat[base], 32'h1234_5478);
      chk("t6_i_rdata", log_dat[base+1], 32'h1234_5578);
    end
    chk("t6_err_after", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
